// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, instruction-memory read, LDM opcode/immediate assembly, IF/ID regs.
// Optional reset-vector fetch from imem word 0 is enabled by defining FETCH_RESET_VEC_MEM_EN.
module fetch_unit #(
    parameter int unsigned     PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic [PC_W-1:0] imem_addr_o,
    input  logic [15:0]     imem_data_i,
    input  logic            pc_enable_i,
    input  logic            stall_i,
    input  logic            jump_taken_i,
    input  logic [PC_W-1:0] jump_target_i,
    output logic [15:0]     if_inst_o,
    output logic [15:0]     if_imm_o,
    output logic [PC_W-1:0] if_pc_next_o,
    output logic            if_valid_o
);

    localparam logic [15:0] Nop   = 16'h4000;
    localparam logic [4:0]  OpLdm = 5'b10001;

`ifdef FETCH_RESET_VEC_MEM_EN
    typedef enum logic [1:0] {StVec, StFetch, StImm} state_e;
    localparam state_e StReset = StVec;
`else
    typedef enum logic [1:0] {StFetch, StImm} state_e;
    localparam state_e StReset = StFetch;
`endif

    state_e          state_q;
    logic [PC_W-1:0] pc_q;
    logic [15:0]     hold_q;
    logic [15:0]     if_inst_q;
    logic [15:0]     if_imm_q;
    logic [PC_W-1:0] if_pc_next_q;
    logic            if_valid_q;

    logic            advance;
    logic            is_ldm;
    logic [PC_W-1:0] pc_inc;

    assign advance = ~stall_i & pc_enable_i;
    assign is_ldm  = (imem_data_i[15:11] == OpLdm);
    assign pc_inc  = pc_q + PC_W'(1);

`ifdef FETCH_RESET_VEC_MEM_EN
    // Zero-extend the vector word so any PC_W works.
    logic [PC_W+15:0] vec_ext;
    logic [PC_W-1:0]  vec_pc;
    assign vec_ext     = {{PC_W{1'b0}}, imem_data_i};
    assign vec_pc      = vec_ext[PC_W-1:0];
    assign imem_addr_o = (state_q == StVec) ? '0 : pc_q;
`else
    assign imem_addr_o = pc_q;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StReset;
            pc_q         <= RESET_PC;
            hold_q       <= '0;
            if_inst_q    <= Nop;
            if_imm_q     <= '0;
            if_pc_next_q <= '0;
            if_valid_q   <= 1'b0;
`ifdef FETCH_RESET_VEC_MEM_EN
        end else if (state_q == StVec) begin
            // Jumps are ignored until the vector has been loaded.
            if (advance) begin
                pc_q    <= vec_pc;
                state_q <= StFetch;
            end
`endif
        end else if (jump_taken_i) begin
            pc_q       <= jump_target_i;
            state_q    <= StFetch;
            hold_q     <= '0;
            if_inst_q  <= Nop;
            if_imm_q   <= '0;
            if_valid_q <= 1'b0;
        end else if (advance) begin
            pc_q <= pc_inc;
            case (state_q)
                StFetch: begin
                    if (is_ldm) begin
                        hold_q     <= imem_data_i;
                        state_q    <= StImm;
                        if_inst_q  <= Nop;
                        if_imm_q   <= '0;
                        if_valid_q <= 1'b0;
                    end else begin
                        if_inst_q    <= imem_data_i;
                        if_imm_q     <= '0;
                        if_pc_next_q <= pc_inc;
                        if_valid_q   <= 1'b1;
                    end
                end
                StImm: begin
                    if_inst_q    <= hold_q;
                    if_imm_q     <= imem_data_i;
                    if_pc_next_q <= pc_inc;
                    if_valid_q   <= 1'b1;
                    state_q      <= StFetch;
                end
                default: ;
            endcase
        end
    end

    assign if_inst_o    = if_inst_q;
    assign if_imm_o     = if_imm_q;
    assign if_pc_next_o = if_pc_next_q;
    assign if_valid_o   = if_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: instruction-level reference model checked every cycle plus directed literals.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        pc_enable;
    logic        stall;
    logic        jump_taken;
    logic [15:0] jump_target;
    logic [15:0] if_inst;
    logic [15:0] if_imm;
    logic [15:0] if_pc_next;
    logic        if_valid;

    logic [15:0] mem [0:65535];

    int n_cmp  = 0;
    int n_fail = 0;

`ifdef FETCH_RESET_VEC_MEM_EN
    localparam bit VecEn = 1'b1;
`else
    localparam bit VecEn = 1'b0;
`endif

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr];

    fetch_unit #(.PC_W(16), .RESET_PC(16'h0000)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .imem_addr_o   (imem_addr),
        .imem_data_i   (imem_data),
        .pc_enable_i   (pc_enable),
        .stall_i       (stall),
        .jump_taken_i  (jump_taken),
        .jump_target_i (jump_target),
        .if_inst_o     (if_inst),
        .if_imm_o      (if_imm),
        .if_pc_next_o  (if_pc_next),
        .if_valid_o    (if_valid)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
        end
    endtask

    // Reference model: tracks the instruction stream, not the RTL's registers.
    bit          m_known = 1'b0;
    bit          m_vec;
    bit          m_pending;
    logic [15:0] m_pc, m_op, m_word;
    logic [15:0] m_inst, m_imm, m_pcn;
    bit          m_valid;

    task automatic m_bubble();
        m_inst  = 16'h4000;
        m_imm   = 16'h0000;
        m_valid = 1'b0;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_known   = 1'b1;
            m_vec     = VecEn;
            m_pc      = 16'h0000;
            m_pending = 1'b0;
            m_pcn     = 16'h0000;
            m_bubble();
        end else if (m_known) begin
            if (m_vec) begin
                if (!stall && pc_enable) begin
                    m_pc  = mem[0];
                    m_vec = 1'b0;
                end
            end else if (jump_taken) begin
                m_pc      = jump_target;
                m_pending = 1'b0;
                m_bubble();
            end else if (!stall && pc_enable) begin
                m_word = mem[m_pc];
                m_pc   = m_pc + 16'd1;
                if (m_pending) begin
                    m_inst    = m_op;
                    m_imm     = m_word;
                    m_pcn     = m_pc;
                    m_valid   = 1'b1;
                    m_pending = 1'b0;
                end else if (m_word[15:11] == 5'b10001) begin
                    m_op      = m_word;
                    m_pending = 1'b1;
                    m_bubble();
                end else begin
                    m_inst  = m_word;
                    m_imm   = 16'h0000;
                    m_pcn   = m_pc;
                    m_valid = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_known) begin
            chk("model_valid", 32'(if_valid), 32'(m_valid));
            chk("model_inst", 32'(if_inst), 32'(m_inst));
            chk("model_imm", 32'(if_imm), 32'(m_imm));
            chk("model_addr", 32'(imem_addr), 32'(m_vec ? 16'h0000 : m_pc));
            if (m_valid) chk("model_pc_next", 32'(if_pc_next), 32'(m_pcn));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string tag, input logic [15:0] inst, input logic [15:0] imm,
                       input logic [15:0] pcn, input logic valid);
        chk({tag, "_valid"}, 32'(if_valid), 32'(valid));
        chk({tag, "_inst"}, 32'(if_inst), 32'(inst));
        chk({tag, "_imm"}, 32'(if_imm), 32'(imm));
        if (valid) chk({tag, "_pc_next"}, 32'(if_pc_next), 32'(pcn));
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'h1000 | 16'(i & 'h7FF);
        rst = 1'b1; stall = 1'b0; pc_enable = 1'b1; jump_taken = 1'b0; jump_target = '0;

`ifdef FETCH_RESET_VEC_MEM_EN
        mem[0] = 16'h0100; mem[16'h0100] = 16'h2345; mem[16'h0101] = 16'h8800;
        step();
        lit("vec_reset", 16'h4000, 16'h0000, 16'h0000, 1'b0);
        chk("vec_addr0", 32'(imem_addr), 32'h0);
        rst = 1'b0; stall = 1'b1; jump_taken = 1'b1; jump_target = 16'h0055;
        step();
        chk("vec_hold_addr", 32'(imem_addr), 32'h0);
        stall = 1'b0; jump_taken = 1'b0;
        step();
        chk("vec_loaded_addr", 32'(imem_addr), 32'h0100);
        lit("vec_bubble", 16'h4000, 16'h0000, 16'h0000, 1'b0);
        step();
        lit("vec_first", 16'h2345, 16'h0000, 16'h0101, 1'b1);
        step();
        lit("vec_imm_bubble", 16'h4000, 16'h0000, 16'h0000, 1'b0);
        rst = 1'b1;
        step();
        lit("vec_rst_mid", 16'h4000, 16'h0000, 16'h0000, 1'b0);
        chk("vec_rst_addr", 32'(imem_addr), 32'h0);
        rst = 1'b0;
        step();
        chk("vec_reload_addr", 32'(imem_addr), 32'h0100);
`else
        mem[0] = 16'h0800; mem[1] = 16'h1000; mem[2] = 16'h4000;
        step();
        lit("reset", 16'h4000, 16'h0000, 16'h0000, 1'b0);
        chk("reset_pc_next", 32'(if_pc_next), 32'h0);
        chk("reset_addr", 32'(imem_addr), 32'h0);
        rst = 1'b0;
        step(); lit("single0", 16'h0800, 16'h0000, 16'h0001, 1'b1);
        step(); lit("single1", 16'h1000, 16'h0000, 16'h0002, 1'b1);
        step(); lit("single2", 16'h4000, 16'h0000, 16'h0003, 1'b1);

        mem[0] = 16'h8800; mem[1] = 16'h1234;
        rst = 1'b1; step(); rst = 1'b0;
        step(); lit("ldm_bubble", 16'h4000, 16'h0000, 16'h0000, 1'b0);
        step(); lit("ldm_pair", 16'h8800, 16'h1234, 16'h0002, 1'b1);
        step(); step(); lit("after_ldm", 16'h1003, 16'h0000, 16'h0004, 1'b1);

        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            lit("stall_hold", 16'h1003, 16'h0000, 16'h0004, 1'b1);
            chk("stall_addr", 32'(imem_addr), 32'h0004);
        end
        jump_taken = 1'b1; jump_target = 16'h0040;
        step();
        lit("jump_bubble", 16'h4000, 16'h0000, 16'h0000, 1'b0);
        chk("jump_addr", 32'(imem_addr), 32'h0040);
        jump_taken = 1'b0; stall = 1'b0;
        step(); lit("jump_first", 16'h1040, 16'h0000, 16'h0041, 1'b1);
        pc_enable = 1'b0;
        step(); lit("pcen_hold", 16'h1040, 16'h0000, 16'h0041, 1'b1);
        pc_enable = 1'b1;

        mem[16'h0041] = 16'h8800;
        step(); lit("imm_state", 16'h4000, 16'h0000, 16'h0000, 1'b0);
        jump_taken = 1'b1; jump_target = 16'h0010;
        step(); lit("flush_imm", 16'h4000, 16'h0000, 16'h0000, 1'b0);
        jump_taken = 1'b0;
        step(); lit("flush_next", 16'h1010, 16'h0000, 16'h0011, 1'b1);

        mem[16'hFFFF] = 16'h8800; mem[0] = 16'h00AA;
        jump_taken = 1'b1; jump_target = 16'hFFFF;
        step(); jump_taken = 1'b0;
        step(); step();
        lit("wrap", 16'h8800, 16'h00AA, 16'h0001, 1'b1);
        chk("wrap_addr", 32'(imem_addr), 32'h0001);

        mem[16'h0020] = 16'h8800;
        jump_taken = 1'b1; jump_target = 16'h0020;
        step(); jump_taken = 1'b0;
        step(); stall = 1'b1; rst = 1'b1;
        step();
        lit("rst_mid_imm", 16'h4000, 16'h0000, 16'h0000, 1'b0);
        chk("rst_mid_addr", 32'(imem_addr), 32'h0);
        rst = 1'b0; stall = 1'b0;

        for (int i = 16'h0100; i < 16'h0140; i++)
            if (i % 3 == 0) mem[i] = 16'h8800 | 16'(i & 'hFF);
        jump_taken = 1'b1; jump_target = 16'h0100;
        step();
        for (int k = 0; k < 60; k++) begin
            stall       = (k % 7 == 3);
            pc_enable   = (k % 11 != 5);
            jump_taken  = (k == 25) || (k == 40);
            jump_target = (k == 25) ? 16'h0104 : 16'h010A;
            step();
        end
        jump_taken = 1'b0; stall = 1'b0; pc_enable = 1'b1;
        step();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage: the producer side of the 16-bit instruction word consumed by the decode-stage control unit. Holds the PC, reads instruction memory, assembles two-word instructions (opcode word + immediate word), and drives the registered IF/ID outputs with a valid flag. It honours stall and pc_enable from downstream and redirects on taken jumps, inserting NOP bubbles where needed.

## Interface
- PC_W, 16, width of PC and instruction-memory address
- RESET_PC, 0, PC value loaded on reset when the reset-vector feature is compiled out
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- imem_addr  output  PC_W  instruction-memory word address; combinational from the PC register, or 0 in VEC state
- imem_data  input  16  instruction-memory read data, asynchronous read of imem_addr
- pc_enable  input  1  0 = freeze fetch; same effect as stall
- stall  input  1  hazard stall from decode; holds PC, state and all IF/ID outputs
- jump_taken  input  1  redirect request from execute
- jump_target  input  PC_W  redirect address
- if_inst  output  16  opcode word to decode (NOP = 16'h4000 when bubble)
- if_imm  output  16  immediate word of a two-word instruction, else 0
- if_pc_next  output  PC_W  address following the full instruction in if_inst
- if_valid  output  1  if_inst/if_imm hold a real instruction

## Operation
- Two-word opcode: imem_data[15:11] == 5'b10001 (LDM). All other opcodes are single-word.
- States: VEC (only with the macro), FETCH, IMM.
- FETCH, advancing: if single-word, if_inst <= imem_data, if_imm <= 0, if_valid <= 1, if_pc_next <= PC+1, PC <= PC+1. If two-word, hold <= imem_data, PC <= PC+1, go IMM, emit bubble (if_inst <= 16'h4000, if_imm <= 0, if_valid <= 0).
- IMM, advancing: if_inst <= hold, if_imm <= imem_data, if_valid <= 1, if_pc_next <= PC+1, PC <= PC+1, go FETCH.
- Advancing means no jump_taken, stall = 0 and pc_enable = 1.
- Stall: when stall = 1 or pc_enable = 0 and no jump_taken, PC, state, hold and all if_* outputs are unchanged.
- Flush: jump_taken = 1 has priority over stall and pc_enable. PC <= jump_target, state <= FETCH, hold is discarded, and a bubble is emitted. A flush in IMM abandons the partial instruction.
- PC arithmetic is modulo 2^PC_W: all-ones + 1 wraps to 0, including across the opcode/immediate pair.

## Timing
- Reset values: PC = RESET_PC (macro off) or undefined until VEC completes (macro on); state = FETCH (macro off) or VEC (macro on); if_inst = 16'h4000; if_imm = 0; if_pc_next = 0; if_valid = 0; hold = 0.
- Latency: a word addressed in cycle N appears on the IF/ID outputs after edge N+1.
- Throughput: single-word instructions 1 per cycle; two-word instructions 1 per 2 cycles, with exactly one bubble before each.
- The first valid instruction after a flush appears one edge after the redirect edge.
- rst asserted mid-operation (including in IMM or while stalled) overrides everything on that edge.

## Configuration
- FETCH_RESET_VEC_MEM_EN defined:
  - Reset enters VEC; imem_addr = 0.
  - On the next advancing edge, PC <= imem_data[PC_W-1:0] (zero-extended if PC_W > 16), state <= FETCH, outputs stay bubble.
  - Stall and pc_enable hold VEC; jump_taken in VEC is ignored.
  - RESET_PC is unused.
- FETCH_RESET_VEC_MEM_EN undefined: no VEC state; PC <= RESET_PC on reset and fetching starts immediately after reset.

## Test plan
- Single-word stream: macro off, RESET_PC=0, mem[0..2]=16'h0800,16'h1000,16'h4000. Required: if_inst 0800/1000/4000 on consecutive cycles with if_valid=1 and if_pc_next=1/2/3.
- Two-word instruction: mem[0]=16'h8800, mem[1]=16'h1234. Required: one bubble (valid=0, inst=4000), then inst=8800, imm=1234, pc_next=2, valid=1.
- Stall/flush priority: stall for 3 cycles mid-stream, then hold stall while asserting jump_taken with target 16'h0040. Required: outputs frozen during the stall; on the jump edge the redirect is taken, a bubble is emitted, and the next valid inst comes from mem[0x40].
- Flush in IMM: jump_taken with target 16'h0010 while in IMM after an 8800 opcode. Required: no valid 8800 is ever emitted; the next valid inst is mem[0x10].
- Wrap-around: PC=16'hFFFF holds 16'h8800 and mem[0]=16'h00AA. Required: inst=8800, imm=00AA, pc_next=0001.
- Reset vector: macro on, mem[0]=16'h0100. Required: one VEC cycle with imem_addr=0, then the first fetch addresses 0x0100; rst mid-IMM returns the block to VEC with outputs at their reset values.
